manual_drive_ctrl: RTL and testbench

- Clocked, parametrised manual-driving controller for the car-simulator top level.
- Replaces the combinational manual-mode state logic with a registered FSM.
- Adds long-press power-on, stall and illegal-gear-shift detection, blinking turn lamps and a saturating odometer.
- Sits between the debounced switch/button inputs and the chassis/LED/7-segment display logic.

---
 rtl/manual_drive_ctrl_if.sv | 42 ++++
 rtl/manual_drive_ctrl.sv | 158 +++++++++++++++
 tb/tb_manual_drive_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/manual_drive_ctrl_if.sv
// Signal bundle between the debounced driver controls and the drive
// controller. Inputs are levels sampled every clock; there is no
// valid/ready handshake on this bus.
interface manual_drive_ctrl_if #(
  parameter int ODO_W = 24
);
  // Driver controls
  logic             power_on_btn;
  logic             power_off_btn;
  logic             throttle;
  logic             clutch;
  logic             brake;
  logic             turn_left;
  logic             turn_right;
  logic             reverse;
  // Controller outputs
  logic [1:0]       state;
  logic             wheel_fwd;
  logic             wheel_bwd;
  logic             steer_left;
  logic             steer_right;
  logic             lamp_left;
  logic             lamp_right;
  logic             fault;
  logic [ODO_W-1:0] odometer;

  // Control source side (switch/button logic, testbench)
  modport master (
    output power_on_btn, power_off_btn, throttle, clutch, brake,
           turn_left, turn_right, reverse,
    input  state, wheel_fwd, wheel_bwd, steer_left, steer_right,
           lamp_left, lamp_right, fault, odometer
  );

  // Controller side
  modport slave (
    input  power_on_btn, power_off_btn, throttle, clutch, brake,
           turn_left, turn_right, reverse,
    output state, wheel_fwd, wheel_bwd, steer_left, steer_right,
           lamp_left, lamp_right, fault, odometer
  );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Manual-driving controller: registered drive FSM with long-press
// power-on, stall / illegal-shift fault pulse, blinking turn lamps and a
// saturating odometer. The FSM state is visible on bus.state.
module manual_drive_ctrl #(
  parameter int POWER_HOLD_CYC = 100_000_000,
  parameter int BLINK_HALF_CYC = 50_000_000,
  parameter int ODO_TICK_CYC   = 10_000_000,
  parameter int ODO_W          = 24
) (
  input  logic                clk,
  input  logic                rst,
  manual_drive_ctrl_if.slave  bus
);

  localparam int HOLD_W  = (POWER_HOLD_CYC > 1) ? $clog2(POWER_HOLD_CYC) : 1;
  localparam int BLINK_W = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;
  localparam int TICK_W  = (ODO_TICK_CYC > 1)   ? $clog2(ODO_TICK_CYC)   : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(POWER_HOLD_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(ODO_TICK_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF          = 2'b00,
    S_NOT_STARTING = 2'b01,
    S_STARTING     = 2'b10,
    S_MOVING       = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rev_q, rev_d;
  logic               fault_q, fault_d;
  logic               odo_clr;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [ODO_W-1:0]   odo_q, odo_d;

  // Next-state logic: power-on hold counter, drive transitions, fault pulse
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    fault_d = 1'b0;
    odo_clr = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (bus.power_on_btn) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_NOT_STARTING;
            odo_clr = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      S_NOT_STARTING: begin
        if (bus.power_off_btn) begin
          state_d = S_OFF;
        end else if (bus.throttle && !bus.clutch) begin
          state_d = S_OFF;      // engine stalls
          fault_d = 1'b1;
        end else if (bus.throttle && bus.clutch && !bus.brake) begin
          state_d = S_STARTING;
        end
      end
      S_STARTING: begin
        if (bus.power_off_btn) begin
          state_d = S_OFF;
        end else if (bus.brake) begin
          state_d = S_NOT_STARTING;
        end else if (bus.throttle && !bus.clutch) begin
          state_d = S_MOVING;
        end
      end
      S_MOVING: begin
        if (bus.power_off_btn) begin
          state_d = S_OFF;
        end else if ((bus.reverse != rev_q) && !bus.clutch) begin
          state_d = S_OFF;      // gear changed without the clutch
          fault_d = 1'b1;
        end else if (bus.brake) begin
          state_d = S_NOT_STARTING;
        end else if (!bus.throttle || bus.clutch) begin
          state_d = S_STARTING;
        end
      end
      default: state_d = S_OFF;
    endcase
    rev_d = bus.reverse;
  end

  // Blink timer: free-runs while powered with any turn request, else idles at phase 0
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if ((state_q != S_OFF) && (bus.turn_left || bus.turn_right)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
      end
    end
  end

  // Odometer: one tick per ODO_TICK_CYC cycles in MOVING, saturating, cleared at power-on
  always_comb begin
    tick_d = '0;
    odo_d  = odo_q;
    if (odo_clr) begin
      odo_d = '0;
    end else if (state_q == S_MOVING) begin
      if (tick_q == TICK_LAST) begin
        if (odo_q != '1) begin
          odo_d = odo_q + ODO_W'(1);
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_OFF;
      hold_q        <= '0;
      rev_q         <= 1'b0;
      fault_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      tick_q        <= '0;
      odo_q         <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      rev_q         <= rev_d;
      fault_q       <= fault_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      tick_q        <= tick_d;
      odo_q         <= odo_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.wheel_fwd   = (state_q == S_MOVING) && !bus.reverse;
  assign bus.wheel_bwd   = (state_q == S_MOVING) &&  bus.reverse;
  assign bus.steer_left  = ((state_q == S_STARTING) || (state_q == S_MOVING)) && bus.turn_left;
  assign bus.steer_right = ((state_q == S_STARTING) || (state_q == S_MOVING)) && bus.turn_right;
  assign bus.lamp_left   = bus.turn_left  && blink_phase_q;
  assign bus.lamp_right  = bus.turn_right && blink_phase_q;
  assign bus.fault       = fault_q;
  assign bus.odometer    = odo_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Bench for manual_drive_ctrl with small timing parameters: a vector
// table with hand-derived expectations, two hand-written corner
// sequences and a random phase, all shadowed by a reference model.
module tb_manual_drive_ctrl;

  localparam int POWER_HOLD_CYC = 10;
  localparam int BLINK_HALF_CYC = 4;
  localparam int ODO_TICK_CYC   = 3;
  localparam int ODO_W          = 2;
  localparam int VW             = 9 + ODO_W;
  localparam int ODO_MAX        = (1 << ODO_W) - 1;

  // Input bit masks, ordered {rst, pon, poff, thr, clu, brk, tl, tr, rev}
  localparam logic [8:0] RUN  = 9'h100;
  localparam logic [8:0] PON  = 9'h080;
  localparam logic [8:0] POFF = 9'h040;
  localparam logic [8:0] THR  = 9'h020;
  localparam logic [8:0] CLU  = 9'h010;
  localparam logic [8:0] BRK  = 9'h008;
  localparam logic [8:0] TL   = 9'h004;
  localparam logic [8:0] TR   = 9'h002;
  localparam logic [8:0] REV  = 9'h001;

  localparam int M_OFF = 0, M_NS = 1, M_ST = 2, M_MV = 3;

  typedef struct packed {
    logic rst, pon, poff, thr, clu, brk, tl, tr, rev;
  } in_t;

  typedef struct {
    in_t           in;
    int            cyc;
    logic [VW-1:0] exp;   // {state, wf, wb, sl, sr, ll, lr, fault, odometer}
  } vec_t;

  logic clk;
  logic rst;
  in_t  drv;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  logic [VW-1:0] exp_q[$];
  vec_t vecs[$];

  // Reference model state (spec-level: elapsed counts, not counters)
  int   m_state, m_press, m_run, m_stint, m_odo;
  logic m_prev_rev, m_fault;

  manual_drive_ctrl_if #(.ODO_W(ODO_W)) bus ();

  manual_drive_ctrl #(
    .POWER_HOLD_CYC(POWER_HOLD_CYC),
    .BLINK_HALF_CYC(BLINK_HALF_CYC),
    .ODO_TICK_CYC  (ODO_TICK_CYC),
    .ODO_W         (ODO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] act();
    return {bus.state, bus.wheel_fwd, bus.wheel_bwd, bus.steer_left, bus.steer_right,
            bus.lamp_left, bus.lamp_right, bus.fault, bus.odometer};
  endfunction

  function automatic vec_t mk(input logic [8:0] in, input int cyc, input logic [1:0] st,
                              input logic [3:0] drive, input logic [1:0] lamps,
                              input logic flt, input logic [ODO_W-1:0] odo);
    vec_t v;
    v.in  = in_t'(in);
    v.cyc = cyc;
    v.exp = {st, drive, lamps, flt, odo};
    return v;
  endfunction

  // Reference model: one clock edge with inputs c
  function automatic void model_step(input in_t c);
    int nxt;
    logic flt;
    if (!c.rst) begin
      m_state = M_OFF; m_press = 0; m_run = 0; m_stint = 0; m_odo = 0;
      m_prev_rev = 1'b0; m_fault = 1'b0;
      return;
    end
    nxt = m_state;
    flt = 1'b0;
    if (m_state == M_OFF) begin
      m_press = c.pon ? m_press + 1 : 0;
      if (m_press == POWER_HOLD_CYC) begin
        nxt = M_NS; m_press = 0; m_odo = 0;
      end
    end else begin
      m_press = 0;
      if (c.poff) nxt = M_OFF;
      else if (m_state == M_NS) begin
        if (c.thr && !c.clu) begin nxt = M_OFF; flt = 1'b1; end
        else if (c.thr && c.clu && !c.brk) nxt = M_ST;
      end else if (m_state == M_ST) begin
        if (c.brk) nxt = M_NS;
        else if (c.thr && !c.clu) nxt = M_MV;
      end else begin
        if ((c.rev != m_prev_rev) && !c.clu) begin nxt = M_OFF; flt = 1'b1; end
        else if (c.brk) nxt = M_NS;
        else if (!c.thr || c.clu) nxt = M_ST;
      end
    end
    if ((m_state != M_OFF) && (c.tl || c.tr)) m_run = m_run + 1;
    else m_run = 0;
    if (m_state == M_MV) begin
      m_stint = m_stint + 1;
      if ((m_stint % ODO_TICK_CYC) == 0 && m_odo < ODO_MAX) m_odo = m_odo + 1;
    end else begin
      m_stint = 0;
    end
    m_prev_rev = c.rev;
    m_state    = nxt;
    m_fault    = flt;
  endfunction

  function automatic logic [VW-1:0] model_out(input in_t c);
    logic mv, drv_ok, ph;
    mv     = (m_state == M_MV);
    drv_ok = (m_state == M_ST) || (m_state == M_MV);
    ph     = ((m_run / BLINK_HALF_CYC) % 2) == 1;
    return {2'(m_state), mv && !c.rev, mv && c.rev, drv_ok && c.tl, drv_ok && c.tr,
            c.tl && ph, c.tr && ph, m_fault, ODO_W'(m_odo)};
  endfunction

  // Driver tasks
  task automatic apply(input in_t v);
    drv               = v;
    rst               = v.rst;
    bus.power_on_btn  = v.pon;
    bus.power_off_btn = v.poff;
    bus.throttle      = v.thr;
    bus.clutch        = v.clu;
    bus.brake         = v.brk;
    bus.turn_left     = v.tl;
    bus.turn_right    = v.tr;
    bus.reverse       = v.rev;
  endtask

  // Scoreboard: compare DUT against the oldest expected entry
  task automatic sb_check();
    logic [VW-1:0] e;
    logic [VW-1:0] a;
    e = exp_q.pop_front();
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model cyc=%0d actual=%b expected=%b", cyc_n, a, e);
    end
  endtask

  task automatic tick();
    in_t cur;
    cur = drv;
    @(posedge clk);
    #1;
    cyc_n++;
    model_step(cur);
    exp_q.push_back(model_out(cur));
    sb_check();
  endtask

  task automatic chk_bit(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, a, e);
    end
  endtask

  initial begin
    in_t r;
    logic ph;
    m_state = M_OFF; m_press = 0; m_run = 0; m_stint = 0; m_odo = 0;
    m_prev_rev = 1'b0; m_fault = 1'b0;

    // drive = {wf, wb, sl, sr}, lamps = {ll, lr}
    vecs.push_back(mk(9'h000,             2,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r0  reset
    vecs.push_back(mk(RUN|PON,            9,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r1  short press
    vecs.push_back(mk(RUN,                1,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r2  release
    vecs.push_back(mk(RUN|PON,            9,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r3
    vecs.push_back(mk(RUN|PON,            1,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r4  10th cycle
    vecs.push_back(mk(RUN|THR|CLU,        1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r5
    vecs.push_back(mk(RUN|THR,            1,  2'd3, 4'b1000, 2'b00, 1'b0, 2'd0)); // r6  move fwd
    vecs.push_back(mk(RUN|THR,            1,  2'd3, 4'b1000, 2'b00, 1'b0, 2'd0)); // r7
    vecs.push_back(mk(RUN|THR|CLU|REV,    1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r8  legal shift
    vecs.push_back(mk(RUN|THR|REV,        1,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd0)); // r9  move bwd
    vecs.push_back(mk(RUN|REV,            1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r10 throttle off
    vecs.push_back(mk(RUN|THR|REV,        1,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd0)); // r11
    vecs.push_back(mk(RUN|THR|REV,        3,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd1)); // r12 odo 1
    vecs.push_back(mk(RUN|THR|REV,        3,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd2)); // r13 odo 2
    vecs.push_back(mk(RUN|THR|REV,        3,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd3)); // r14 odo 3
    vecs.push_back(mk(RUN|THR|REV,        3,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd3)); // r15 saturated
    vecs.push_back(mk(RUN|THR|BRK|REV,    1,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd3)); // r16 brake wins
    vecs.push_back(mk(RUN|THR|REV,        1,  2'd0, 4'b0000, 2'b00, 1'b1, 2'd3)); // r17 stall
    vecs.push_back(mk(RUN|REV,            1,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd3)); // r18 pulse over
    vecs.push_back(mk(RUN|PON|REV,        10, 2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r19 odo cleared
    vecs.push_back(mk(RUN|THR|CLU|REV,    1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r20
    vecs.push_back(mk(RUN|THR|BRK|REV,    1,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r21 brake in 10
    vecs.push_back(mk(RUN|THR|CLU|REV,    1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r22
    vecs.push_back(mk(RUN|THR|REV,        1,  2'd3, 4'b0100, 2'b00, 1'b0, 2'd0)); // r23
    vecs.push_back(mk(RUN|THR,            1,  2'd0, 4'b0000, 2'b00, 1'b1, 2'd0)); // r24 illegal shift
    vecs.push_back(mk(RUN,                1,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r25
    vecs.push_back(mk(RUN|PON,            10, 2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r26
    vecs.push_back(mk(RUN|THR|CLU,        1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r27
    vecs.push_back(mk(RUN|THR,            1,  2'd3, 4'b1000, 2'b00, 1'b0, 2'd0)); // r28
    vecs.push_back(mk(RUN|THR|POFF,       1,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r29 power off
    vecs.push_back(mk(RUN|PON,            10, 2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r30
    vecs.push_back(mk(RUN|TL|TR,          3,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r31 hazard dark
    vecs.push_back(mk(RUN|TL|TR,          1,  2'd1, 4'b0000, 2'b11, 1'b0, 2'd0)); // r32 first lit
    vecs.push_back(mk(RUN|TL|TR,          3,  2'd1, 4'b0000, 2'b11, 1'b0, 2'd0)); // r33
    vecs.push_back(mk(RUN|TL|TR,          1,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r34
    vecs.push_back(mk(RUN|TL|TR,          4,  2'd1, 4'b0000, 2'b11, 1'b0, 2'd0)); // r35
    vecs.push_back(mk(RUN,                1,  2'd1, 4'b0000, 2'b00, 1'b0, 2'd0)); // r36 requests off
    vecs.push_back(mk(RUN|THR|CLU,        1,  2'd2, 4'b0000, 2'b00, 1'b0, 2'd0)); // r37
    vecs.push_back(mk(RUN|THR|TL,         1,  2'd3, 4'b1010, 2'b00, 1'b0, 2'd0)); // r38 steer left
    vecs.push_back(mk(RUN|THR|TL,         2,  2'd3, 4'b1010, 2'b00, 1'b0, 2'd0)); // r39
    vecs.push_back(mk(THR|TL,             1,  2'd0, 4'b0000, 2'b00, 1'b0, 2'd0)); // r40 reset mid-move

    // Vector table
    foreach (vecs[i]) begin
      apply(vecs[i].in);
      repeat (vecs[i].cyc) tick();
      checks++;
      if (act() !== vecs[i].exp) begin
        errors++;
        $display("FAIL vector_%0d actual=%b expected=%b", i, act(), vecs[i].exp);
      end
    end

    // Legal reverse change under clutch while moving: drive direction follows at once
    apply(in_t'(RUN|PON));
    repeat (POWER_HOLD_CYC) tick();
    chk_bit("power_on_state", bus.state == 2'b01, 1'b1);
    apply(in_t'(RUN|THR|CLU));
    tick();
    apply(in_t'(RUN|THR));
    tick();
    apply(in_t'(RUN|THR|CLU|REV));
    #1;
    chk_bit("legal_rev_wheel_bwd", bus.wheel_bwd, 1'b1);
    chk_bit("legal_rev_wheel_fwd", bus.wheel_fwd, 1'b0);
    tick();
    chk_bit("legal_rev_no_fault", bus.fault, 1'b0);
    chk_bit("legal_rev_starting", bus.state == 2'b10, 1'b1);

    // Hazard blink over two full periods in STARTING, steering follows requests
    apply(in_t'(RUN|REV|TL|TR));
    for (int k = 1; k <= 4 * BLINK_HALF_CYC; k++) begin
      tick();
      ph = ((k / BLINK_HALF_CYC) % 2) == 1;
      chk_bit("hazard_lamp_left", bus.lamp_left, ph);
      chk_bit("hazard_lamp_right", bus.lamp_right, ph);
      chk_bit("hazard_steer_left", bus.steer_left, 1'b1);
    end

    // Random stimulus against the model
    r = drv;
    for (int k = 0; k < 3000; k++) begin
      r.rst  = ($urandom_range(0, 199) != 0);
      r.pon  = ($urandom_range(0, 9) != 0);
      r.poff = ($urandom_range(0, 49) == 0);
      r.thr  = 1'($urandom_range(0, 1));
      r.clu  = 1'($urandom_range(0, 1));
      r.brk  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) r.rev = ~r.rev;
      if ($urandom_range(0, 7) == 0) r.tl = ~r.tl;
      if ($urandom_range(0, 7) == 0) r.tr = ~r.tr;
      apply(r);
      tick();
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
